// File: rtl/uart_gpio_pkg.sv
// -----------------------------------------------------------------------------
// uart_gpio_pkg
// Shared definitions for the UART byte-command GPIO bridge: opcode values,
// reply bytes, error codes, FSM state encoding and small opcode decoders.
// -----------------------------------------------------------------------------
package uart_gpio_pkg;

  // Opcode lives in the upper nibble of the command byte, port in the lower.
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_SET   = 4'd2;
  localparam logic [3:0] OP_CLR   = 4'd3;
  localparam logic [3:0] OP_READ  = 4'd4;
  localparam logic [3:0] OP_RBACK = 4'd5;

  localparam logic [7:0] ACK_BYTE = 8'hAC;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_CMD = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ARG   = 3'd1,
    ST_EXEC      = 3'd2,
    ST_SEND      = 3'd3,
    ST_SEND_WAIT = 3'd4
  } state_e;

  // Write-type commands carry one argument byte after the opcode.
  function automatic logic op_takes_arg(input logic [3:0] op);
    return (op == OP_WRITE) || (op == OP_SET) || (op == OP_CLR);
  endfunction

  function automatic logic op_is_known(input logic [3:0] op);
    return (op >= OP_WRITE) && (op <= OP_RBACK);
  endfunction

endpackage

// File: rtl/uart_gpio_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_gpio_bridge_if
// Byte-stream handshake between the UART serdes and the GPIO bridge.
//   rx_data/rx_valid : received byte with 1-cycle strobe (UART -> bridge)
//   tx_data/tx_start : reply byte with 1-cycle launch strobe (bridge -> UART)
//   tx_busy          : transmitter busy (UART -> bridge)
// master = UART side, slave = bridge side.
// -----------------------------------------------------------------------------
interface uart_gpio_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_start
  );

  modport slave (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_start
  );
endinterface

// File: rtl/gpio_in_sync.sv
// -----------------------------------------------------------------------------
// gpio_in_sync
// Two-flop synchroniser for asynchronous GPIO inputs.
//   clk, rst_n : clock, async active-low reset (both stages clear to 0)
//   d          : asynchronous input bus, WIDTH bits
//   q          : synchronised output, two clk cycles behind d
// -----------------------------------------------------------------------------
module gpio_in_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // NOTE: flops take non-blocking assignments so every stage samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_gpio_bridge.sv
// -----------------------------------------------------------------------------
// uart_gpio_bridge
// Byte-command GPIO expander. Decodes {op, port} command bytes from the UART
// receiver, updates NUM_PORTS registered 8-bit outputs, reads synchronised
// inputs and returns ACK/NAK/data bytes to the UART transmitter.
//   clk, rst_n : clock, async active-low reset
//   uart       : byte handshake (slave modport)
//   gp_in      : async inputs, port p at [8p+7:8p]
//   gp_out     : registered outputs, port p at [8p+7:8p]
//   cmd_done   : 1-cycle pulse per successfully completed command
//   err_pulse  : 1-cycle pulse per error
//   err_code   : last error (1 bad cmd, 2 timeout, 3 rx overrun), held
// -----------------------------------------------------------------------------
module uart_gpio_bridge
  import uart_gpio_pkg::*;
#(
  parameter int         NUM_PORTS      = 4,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter bit         ACK_EN         = 1'b1,
  parameter logic [7:0] OUT_RST        = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_gpio_bridge_if.slave      uart,
  input  logic [8*NUM_PORTS-1:0] gp_in,
  output logic [8*NUM_PORTS-1:0] gp_out,
  output logic                   cmd_done,
  output logic                   err_pulse,
  output logic [1:0]             err_code
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  // The FSM leaves GET_ARG on the edge where the counter would reach
  // TIMEOUT_CYCLES-1, so the error surfaces TIMEOUT_CYCLES after the opcode.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [3:0]        port_q, port_d;
  logic [7:0]        arg_q, arg_d;
  logic [7:0]        reply_q, reply_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              done_q, done_d;
  logic              err_pulse_q, err_pulse_d;
  err_code_e         err_code_q, err_code_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;

  logic [7:0]        port_reg  [NUM_PORTS];
  logic [7:0]        sync_byte [NUM_PORTS];
  logic [8*NUM_PORTS-1:0] gp_sync;

  logic [PORT_W-1:0] port_idx;
  logic              cmd_ok;
  logic [7:0]        cur_byte;
  logic              wr_en;
  logic [7:0]        wr_val;
  logic              reply_due;
  logic [7:0]        reply_val;

  gpio_in_sync #(.WIDTH(8 * NUM_PORTS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gp_in),
    .q     (gp_sync)
  );

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign sync_byte[p]     = gp_sync[8*p +: 8];
    assign gp_out[8*p +: 8] = port_reg[p];
  end

  assign port_idx = port_q[PORT_W-1:0];
  assign cmd_ok   = op_is_known(op_q) && (int'(port_q) < NUM_PORTS);
  assign cur_byte = port_reg[port_idx];

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first; any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    port_d      = port_q;
    arg_d       = arg_q;
    reply_d     = reply_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    done_d      = 1'b0;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    tmo_d       = '0;
    wr_en       = 1'b0;
    wr_val      = cur_byte;
    reply_due   = 1'b0;
    reply_val   = NAK_BYTE;

    case (state_q)
      ST_IDLE: begin
        if (uart.rx_valid) begin
          op_d    = uart.rx_data[7:4];
          port_d  = uart.rx_data[3:0];
          // The argument of a write-type opcode is consumed even if the
          // port is out of range, so the NAK lines up with the byte stream.
          state_d = op_takes_arg(uart.rx_data[7:4]) ? ST_GET_ARG : ST_EXEC;
        end
      end

      ST_GET_ARG: begin
        if (uart.rx_valid) begin
          arg_d   = uart.rx_data;
          state_d = ST_EXEC;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_IDLE;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      ST_EXEC: begin
        if (!cmd_ok) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_BAD_CMD;
          reply_due   = 1'b1;
          reply_val   = NAK_BYTE;
        end else begin
          done_d = 1'b1;
          case (op_q)
            OP_WRITE: begin wr_en = 1'b1; wr_val = arg_q;             reply_due = ACK_EN; reply_val = ACK_BYTE; end
            OP_SET:   begin wr_en = 1'b1; wr_val = cur_byte | arg_q;  reply_due = ACK_EN; reply_val = ACK_BYTE; end
            OP_CLR:   begin wr_en = 1'b1; wr_val = cur_byte & ~arg_q; reply_due = ACK_EN; reply_val = ACK_BYTE; end
            OP_READ:  begin reply_due = 1'b1; reply_val = sync_byte[port_idx]; end
            default:  begin reply_due = 1'b1; reply_val = cur_byte; end
          endcase
        end

        // SEND is skipped when the transmitter is already idle so the
        // launch strobe lands on the same edge as the gp_out update.
        if (reply_due) begin
          if (!uart.tx_busy) begin
            tx_data_d  = reply_val;
            tx_start_d = 1'b1;
            state_d    = ST_SEND_WAIT;
          end else begin
            reply_d = reply_val;
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (!uart.tx_busy) begin
          tx_data_d  = reply_q;
          tx_start_d = 1'b1;
          state_d    = ST_SEND_WAIT;
        end
      end

      ST_SEND_WAIT: begin
        // tx_start_q is high only in the first SEND_WAIT cycle, which is
        // the one cycle the transmitter gets to raise tx_busy.
        if (!tx_start_q && !uart.tx_busy) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A byte arriving while a command is being executed or replied to is
    // dropped. A bad-command error in the same cycle keeps its code.
    if (uart.rx_valid && (state_q inside {ST_EXEC, ST_SEND, ST_SEND_WAIT})
        && !err_pulse_d) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_OVERRUN;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      port_q      <= '0;
      arg_q       <= '0;
      reply_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      port_q      <= port_d;
      arg_q       <= arg_d;
      reply_q     <= reply_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      done_q      <= done_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      tmo_q       <= tmo_d;
    end
  end

  // NOTE: the port array drives pins directly and must come out of reset at
  // OUT_RST, so unlike a RAM every entry is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) port_reg[p] <= OUT_RST;
    end else if (wr_en) begin
      port_reg[port_idx] <= wr_val;
    end
  end

  assign uart.tx_data  = tx_data_q;
  assign uart.tx_start = tx_start_q;
  assign cmd_done      = done_q;
  assign err_pulse     = err_pulse_q;
  assign err_code      = err_code_q;

endmodule
